phy2mac_driver_iface: RTL and testbench

Per-lane generator of the PIPE receive-side symbol stream that the PHY model presents to the MAC. From the lane's current LTSSM state it emits continuous TS1 or TS2 ordered sets, or idle symbols, on rxdata/rxdatak with rxvalid. One instance exists per lane, between the lane LTSSM and the MAC-facing rx bus. An optional 8b/10b encoder adds a 10-bit line-symbol view.

---
 rtl/phy2mac_driver_iface.sv | 164 ++++++++++++++++
 tb/tb_phy2mac_driver_iface.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/phy2mac_driver_iface.sv
// Per-lane PIPE rx symbol generator: TS1/TS2 ordered sets or idle, chosen from the lane LTSSM state.
// Define ENCODE_10B_EN to add the rxsym10b 8b/10b line-symbol output with running disparity.
module phy2mac_driver_iface (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  currLtssmState,
    input  logic        en_n,
    input  logic [39:0] ts1Bytes1Thru5,
    input  logic [39:0] ts2Bytes1Thru5,
    output logic [7:0]  rxdata,
    output logic        rxdatak,
    output logic        rxvalid
`ifdef ENCODE_10B_EN
    ,
    output logic [9:0]  rxsym10b
`endif
);

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [1:0] {SET_NONE, SET_TS1, SET_TS2} set_t;

    set_t        set_type, set_type_next, req_type, sym_type;
    logic [3:0]  sym_cnt, sym_cnt_next;
    logic        mode_off, mode_idle;
    logic [39:0] ts_bytes;
    logic [7:0]  ts_byte;
    logic [7:0]  data_next;
    logic        k_next, valid_next;

    // State register. rxvalid has no back-pressure: every cycle with rxvalid=1 carries one symbol the MAC must accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_type <= SET_NONE;
            sym_cnt  <= 4'd0;
            rxdata   <= 8'h00;
            rxdatak  <= 1'b0;
            rxvalid  <= 1'b0;
        end else begin
            set_type <= set_type_next;
            sym_cnt  <= sym_cnt_next;
            rxdata   <= data_next;
            rxdatak  <= k_next;
            rxvalid  <= valid_next;
        end
    end

    // Next state: set type is only re-latched at COM, so a TS1/TS2 change mid-set waits for the next set.
    always_comb begin
        req_type      = SET_NONE;
        set_type_next = set_type;
        sym_cnt_next  = sym_cnt;
        case (currLtssmState)
            3'd3, 3'd5: req_type = SET_TS1;
            3'd4:       req_type = SET_TS2;
            default:    req_type = SET_NONE;
        endcase
        mode_idle = !en_n && (currLtssmState == 3'd2);
        mode_off  = en_n || ((req_type == SET_NONE) && !mode_idle);
        sym_type  = (sym_cnt == 4'd0) ? req_type : set_type;
        if (mode_off) begin
            set_type_next = SET_NONE;
            sym_cnt_next  = 4'd0;
        end else if (mode_idle) begin
            sym_cnt_next  = 4'd0;
        end else begin
            set_type_next = sym_type;
            sym_cnt_next  = sym_cnt + 4'd1;
        end
    end

    // Output decode for the symbol about to be registered.
    always_comb begin
        data_next  = 8'h00;
        k_next     = 1'b0;
        valid_next = !mode_off;
        ts_bytes   = (sym_type == SET_TS2) ? ts2Bytes1Thru5 : ts1Bytes1Thru5;
        ts_byte    = ts_bytes[7:0];
        case (sym_cnt)
            4'd1:    ts_byte = ts_bytes[39:32];
            4'd2:    ts_byte = ts_bytes[31:24];
            4'd3:    ts_byte = ts_bytes[23:16];
            4'd4:    ts_byte = ts_bytes[15:8];
            default: ts_byte = ts_bytes[7:0];
        endcase
        if (!mode_off && !mode_idle) begin
            if (sym_cnt == 4'd0) begin
                data_next = COM;
                k_next    = 1'b1;
            end else if (sym_cnt <= 4'd5) begin
                data_next = ts_byte;
                k_next    = (sym_cnt <= 4'd2) && (ts_byte == PAD);
            end else begin
                data_next = (sym_type == SET_TS2) ? TS2_ID : TS1_ID;
            end
        end
    end

`ifdef ENCODE_10B_EN
    logic rd;

    // Returns {rd_out, j,h,g,f,i,e,d,c,b,a}; rd encodes running disparity with 1 = positive.
    function automatic logic [10:0] enc_8b10b(input logic [7:0] d, input logic k, input logic rd_in);
        logic [5:0] c6;
        logic [3:0] c4;
        logic [4:0] x;
        logic [2:0] y;
        logic       bal6, bal4, rd_mid, alt7;
        x = d[4:0];
        y = d[7:5];
        case (x)
            5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
            5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
        endcase
        if (k && (x == 5'd28))
            c6 = 6'b001111;
        bal6 = ($countones(c6) == 3);
        if (rd_in && (!bal6 || (x == 5'd7)))
            c6 = ~c6;
        rd_mid = bal6 ? rd_in : ~rd_in;
        // Alternate x.7 avoids a run of five identical bits across the 6b/4b boundary.
        alt7 = (y == 3'd7) && (k || (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                               (rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = alt7 ? 4'b0111 : 4'b1110;
        endcase
        bal4 = ($countones(c4) == 2);
        if (rd_mid && (!bal4 || (y == 3'd3)))
            c4 = ~c4;
        if (k && (x == 5'd28) && !rd_mid && bal4 && (y != 3'd3))
            c4 = ~c4;
        return {(bal4 ? rd_mid : ~rd_mid), c4[0], c4[1], c4[2], c4[3],
                c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd       <= 1'b0;
            rxsym10b <= 10'd0;
        end else if (rxvalid) begin
            {rd, rxsym10b} <= enc_8b10b(rxdata, rxdatak, rd);
        end else begin
            rxsym10b <= 10'd0;
        end
    end
`endif

endmodule

// File: tb/tb_phy2mac_driver_iface.sv
// Self-checking bench for phy2mac_driver_iface: behavioural symbol model feeding an expected queue.
// The rxsym10b checks are compiled only when ENCODE_10B_EN is defined.
module tb_phy2mac_driver_iface;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  currLtssmState;
    logic        en_n;
    logic [39:0] ts1Bytes1Thru5;
    logic [39:0] ts2Bytes1Thru5;
    logic [7:0]  rxdata;
    logic        rxdatak;
    logic        rxvalid;
`ifdef ENCODE_10B_EN
    logic [9:0]  rxsym10b;
`endif

    phy2mac_driver_iface dut (
        .clk            (clk),
        .reset          (reset),
        .currLtssmState (currLtssmState),
        .en_n           (en_n),
        .ts1Bytes1Thru5 (ts1Bytes1Thru5),
        .ts2Bytes1Thru5 (ts2Bytes1Thru5),
        .rxdata         (rxdata),
        .rxdatak        (rxdatak),
        .rxvalid        (rxvalid)
`ifdef ENCODE_10B_EN
        ,
        .rxsym10b       (rxsym10b)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];

    int         m_pos;
    int         m_type;
    bit         m_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {rxvalid, rxdatak, rxdata} for the inputs currently driven.
    task automatic model_step(input logic [2:0] st, input logic en, output logic [9:0] e);
        logic [39:0] sh;
        logic [7:0]  b;
        int          req;
        e = '0;
        if (en || st == 3'd0 || st == 3'd1 || st >= 3'd6) begin
            m_active = 0;
            m_type   = 0;
        end else if (st == 3'd2) begin
            m_active = 0;
            e = 10'h200;
        end else begin
            req = (st == 3'd4) ? 2 : 1;
            if (!m_active) begin
                m_active = 1;
                m_pos    = 0;
            end
            if (m_pos == 0) begin
                m_type = req;
                e = {2'b11, 8'hBC};
            end else if (m_pos <= 5) begin
                sh = (m_type == 2) ? ts2Bytes1Thru5 : ts1Bytes1Thru5;
                sh = sh >> (8 * (5 - m_pos));
                b  = sh[7:0];
                e  = {1'b1, (m_pos <= 2) && (b == 8'hF7), b};
            end else begin
                e = {2'b10, (m_type == 2) ? 8'h45 : 8'h4A};
            end
            m_pos = (m_pos + 1) % 16;
        end
    endtask

`ifdef ENCODE_10B_EN
    logic [9:0] prev_e;
    bit         rd;
    bit         rd_known;

    // Reference code groups as written abcdei fghj: {known, code}.
    function automatic logic [10:0] ref_code(input logic [8:0] kd, input bit rdp);
        case (kd)
            9'h1BC:  return {1'b1, rdp ? 10'b1100000101 : 10'b0011111010};
            9'h1F7:  return {1'b1, rdp ? 10'b0001010111 : 10'b1110101000};
            9'h0F7:  return {1'b1, rdp ? 10'b0001011110 : 10'b1110100001};
            9'h008:  return {1'b1, rdp ? 10'b0001101011 : 10'b1110010100};
            9'h002:  return {1'b1, rdp ? 10'b0100101011 : 10'b1011010100};
            9'h004:  return {1'b1, rdp ? 10'b0010101011 : 10'b1101010100};
            9'h000:  return {1'b1, rdp ? 10'b0110001011 : 10'b1001110100};
            9'h04A:  return {1'b1, 10'b0101010101};
            9'h045:  return {1'b1, 10'b1010010101};
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9 - i];
        return r;
    endfunction

    task automatic check_10b(input logic [9:0] cur);
        logic [10:0] r;
        int          ones;
        if (!prev_e[9]) begin
            check("sym10b_off", {22'd0, rxsym10b}, 32'd0);
        end else if (rd_known) begin
            r = ref_code(prev_e[8:0], rd);
            if (r[10]) begin
                check("sym10b", {22'd0, rxsym10b}, {22'd0, rev10(r[9:0])});
                ones = $countones(r[9:0]);
                if (ones > 5) rd = 1;
                else if (ones < 5) rd = 0;
            end else begin
                rd_known = 0;
            end
        end
        prev_e = cur;
    endtask
`endif

    task automatic model_reset();
        m_active = 0;
        m_type   = 0;
        m_pos    = 0;
        exp_q.delete();
`ifdef ENCODE_10B_EN
        prev_e   = '0;
        rd       = 0;
        rd_known = 1;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxdata"},  {24'd0, rxdata}, 32'd0);
        check({tag, "_rxdatak"}, {31'd0, rxdatak}, 32'd0);
        check({tag, "_rxvalid"}, {31'd0, rxvalid}, 32'd0);
`ifdef ENCODE_10B_EN
        check({tag, "_sym10b"},  {22'd0, rxsym10b}, 32'd0);
`endif
    endtask

    // Driver: drive at negedge, predict, compare at the following negedge.
    task automatic tick(input logic [2:0] st, input logic en);
        logic [9:0] e;
        currLtssmState = st;
        en_n           = en;
        model_step(st, en, e);
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rx", {22'd0, rxvalid, rxdatak, rxdata}, {22'd0, e});
`ifdef ENCODE_10B_EN
        check_10b(e);
`endif
    endtask

    function automatic logic [39:0] rand_ts();
        logic [39:0] r;
        logic [7:0]  b;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'hF7 : 8'($urandom_range(0, 255));
            r = {r[31:0], b};
        end
        return r;
    endfunction

    initial begin
        logic [2:0] cur_st;
        logic       cur_en;
        reset          = 1'b1;
        currLtssmState = 3'd3;
        en_n           = 1'b0;
        ts1Bytes1Thru5 = {8'h08, 8'h02, 8'h04, 8'hF7, 8'hF7};
        ts2Bytes1Thru5 = {8'hF7, 8'hF7, 8'h08, 8'h02, 8'h04};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // TS1 stream, then asynchronous reset mid-set
        for (int i = 0; i < 20; i++) tick(3'd3, 1'b0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Two full TS1 sets back-to-back, then TS2 requested at symbol 7
        for (int i = 0; i < 32; i++) tick(3'd3, 1'b0);
        for (int i = 0; i < 20 && m_pos != 7; i++) tick(3'd3, 1'b0);
        for (int i = 0; i < 30; i++) tick(3'd4, 1'b0);

        // Electrical idle mid-set, then resume
        for (int i = 0; i < 20 && m_pos != 9; i++) tick(3'd4, 1'b0);
        for (int i = 0; i < 3; i++) tick(3'd4, 1'b1);
        for (int i = 0; i < 20; i++) tick(3'd4, 1'b0);

        // Idle, detect, TS1 via CONFIG_LINKWIDTH_START, states 6/7
        for (int i = 0; i < 5; i++) tick(3'd2, 1'b0);
        for (int i = 0; i < 3; i++) tick(3'd0, 1'b0);
        for (int i = 0; i < 20; i++) tick(3'd5, 1'b0);
        tick(3'd6, 1'b0);
        tick(3'd7, 1'b0);
        tick(3'd1, 1'b0);
        for (int i = 0; i < 8; i++) tick(3'd3, 1'b0);
        for (int i = 0; i < 3; i++) tick(3'd2, 1'b0);
        for (int i = 0; i < 18; i++) tick(3'd3, 1'b0);

        // Random states, enables and TS contents
        cur_st = 3'd3;
        cur_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) cur_st = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) cur_en = ~cur_en;
            ts1Bytes1Thru5 = rand_ts();
            ts2Bytes1Thru5 = rand_ts();
            tick(cur_st, cur_en);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
